// File: rtl/ncl_dr_pkg.sv
// rtl/ncl_dr_pkg.sv - dual-rail (NCL-style) encoding constants and helpers
// Purpose: shared dual-rail pair encoding for the ALU pipeline stage.
//   A logical bit travels on two wires {hi, lo}: 00 NULL, 01 DATA0, 10 DATA1, 11 illegal.
// Contents: DR_* pair constants, stage state enum, pair encode/decode/classify functions.
package ncl_dr_pkg;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_0    = 2'b01;
  localparam logic [1:0] DR_1    = 2'b10;

  // Output register content: a NULL spacer or a DATA wavefront.
  typedef enum logic {
    ST_NULL = 1'b0,
    ST_DATA = 1'b1
  } stage_state_e;

  function automatic logic [1:0] dr_encode(input logic bit_v);
    return bit_v ? DR_1 : DR_0;
  endfunction

  // Only meaningful for a DATA pair; the caller qualifies with dr_is_data.
  function automatic logic dr_decode(input logic [1:0] pair);
    return (pair == DR_1);
  endfunction

  function automatic logic dr_is_data(input logic [1:0] pair);
    return (pair == DR_0) || (pair == DR_1);
  endfunction

  function automatic logic dr_is_null(input logic [1:0] pair);
    return (pair == DR_NULL);
  endfunction

endpackage

// File: rtl/ncl_dr_alu.sv
// rtl/ncl_dr_alu.sv - combinational dual-rail add/sub with flags and wavefront detect
// Purpose: decode dual-rail operands, compute W-bit two's complement add/sub with
//   overflow/negative/zero flags, and re-encode everything as dual-rail DATA.
// Ports:
//   a, b        in  2W  operands, dual-rail
//   opr         in  2   dual-rail op: logical 0 = ADD, logical 1 = SUB (a-b)
//   soma        out 2W  result, dual-rail DATA
//   of/neg/zero out 2   flags, dual-rail DATA
//   in_complete out 1   every input pair is DATA0 or DATA1
//   in_null     out 1   every input wire is 0
module ncl_dr_alu #(
  parameter int W = 4
) (
  input  logic [2*W-1:0] a,
  input  logic [2*W-1:0] b,
  input  logic [1:0]     opr,
  output logic [2*W-1:0] soma,
  output logic [1:0]     of,
  output logic [1:0]     neg,
  output logic [1:0]     zero,
  output logic           in_complete,
  output logic           in_null
);
  import ncl_dr_pkg::*;

  logic [W-1:0] a_v;
  logic [W-1:0] b_v;
  logic [W-1:0] b_eff;
  logic [W-1:0] r;
  logic         sub;
  logic         ovf;

  always_comb begin
    a_v         = '0;
    b_v         = '0;
    soma        = '0;
    in_complete = dr_is_data(opr);
    in_null     = dr_is_null(opr);
    for (int i = 0; i < W; i++) begin
      a_v[i]      = dr_decode(a[2*i +: 2]);
      b_v[i]      = dr_decode(b[2*i +: 2]);
      in_complete = in_complete & dr_is_data(a[2*i +: 2]) & dr_is_data(b[2*i +: 2]);
      in_null     = in_null & dr_is_null(a[2*i +: 2]) & dr_is_null(b[2*i +: 2]);
    end

    // SUB is a + ~b + 1; the carry out of the W-bit sum is dropped.
    sub   = dr_decode(opr);
    b_eff = sub ? ~b_v : b_v;
    r     = a_v + b_eff + {{(W-1){1'b0}}, sub};

    // Signed overflow: both addends share a sign that the result does not.
    ovf = (a_v[W-1] == b_eff[W-1]) && (r[W-1] != a_v[W-1]);

    for (int i = 0; i < W; i++) begin
      soma[2*i +: 2] = dr_encode(r[i]);
    end
    of   = dr_encode(ovf);
    neg  = dr_encode(r[W-1]);
    zero = dr_encode(r == '0);
  end

endmodule

// File: rtl/estagio_ula_1000_core.sv
// rtl/estagio_ula_1000_core.sv - registered dual-rail ALU pipeline stage with 4-phase ack
// Purpose: one stage of a self-timed-style ALU pipeline, implemented synchronously.
//   Captures a computed DATA wavefront when holding NULL and the next stage asks for DATA,
//   and captures NULL when holding DATA and the next stage asks for NULL.
// Ports:
//   clk          in  1   rising-edge clock
//   rst          in  1   synchronous, active-high reset
//   a, b         in  2W  operands, dual-rail
//   opr          in  2   dual-rail op: logical 0 = ADD, logical 1 = SUB
//   ack_in       in  1   next stage: 1 = ready for DATA, 0 = ready for NULL
//   soma         out 2W  registered result, dual-rail
//   of/neg/zero  out 2   registered flags, dual-rail
//   ack_out      out 1   1 = output holds NULL, 0 = output holds DATA
module estagio_ula_1000_core #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2*W-1:0] a,
  input  logic [2*W-1:0] b,
  input  logic [1:0]     opr,
  input  logic           ack_in,
  output logic [2*W-1:0] soma,
  output logic [1:0]     of,
  output logic [1:0]     neg,
  output logic [1:0]     zero,
  output logic           ack_out
);
  import ncl_dr_pkg::*;

  stage_state_e   state;
  stage_state_e   state_nx;
  logic           load_data;
  logic           load_null;
  logic [2*W-1:0] alu_soma;
  logic [1:0]     alu_of;
  logic [1:0]     alu_neg;
  logic [1:0]     alu_zero;
  logic           in_complete;
  logic           in_null;

  ncl_dr_alu #(.W(W)) u_alu (
    .a           (a),
    .b           (b),
    .opr         (opr),
    .soma        (alu_soma),
    .of          (alu_of),
    .neg         (alu_neg),
    .zero        (alu_zero),
    .in_complete (in_complete),
    .in_null     (in_null)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_NULL;
      soma  <= '0;
      of    <= DR_NULL;
      neg   <= DR_NULL;
      zero  <= DR_NULL;
    end else begin
      state <= state_nx;
      if (load_data) begin
        soma <= alu_soma;
        of   <= alu_of;
        neg  <= alu_neg;
        zero <= alu_zero;
      end else if (load_null) begin
        soma <= '0;
        of   <= DR_NULL;
        neg  <= DR_NULL;
        zero <= DR_NULL;
      end
    end
  end

  // Partial, mixed or illegal wavefronts never qualify, so the stage simply holds.
  always_comb begin
    state_nx  = state;
    load_data = 1'b0;
    load_null = 1'b0;
    case (state)
      ST_NULL: begin
        if (ack_in && in_complete) begin
          load_data = 1'b1;
          state_nx  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!ack_in && in_null) begin
          load_null = 1'b1;
          state_nx  = ST_NULL;
        end
      end
      default: state_nx = ST_NULL;
    endcase
  end

  // Comes straight off the state flop, so it tracks the NULL/DATA content of the outputs.
  assign ack_out = (state == ST_NULL);

endmodule

// File: tb/tb_estagio_ula_1000_core.sv
// tb/tb_estagio_ula_1000_core.sv - scoreboard bench for the dual-rail ALU stage
module tb_estagio_ula_1000_core;
  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic [1:0] opr = 2'b00;
  logic       ack_in = 1'b0;
  logic [7:0] soma;
  logic [1:0] of;
  logic [1:0] neg;
  logic [1:0] zero;
  logic       ack_out;

  always #5 clk = ~clk;

  estagio_ula_1000_core #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .opr     (opr),
    .ack_in  (ack_in),
    .soma    (soma),
    .of      (of),
    .neg     (neg),
    .zero    (zero),
    .ack_out (ack_out)
  );

  typedef struct {
    logic [7:0] soma;
    logic [1:0] of;
    logic [1:0] neg;
    logic [1:0] zero;
    logic       ack;
    int         due;
    int         tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   check_on = 0;
  logic [13:0] mon_w;
  bit   mon_bad;

  // Reference state: what the output register should be holding.
  logic [7:0] m_soma = 8'h00;
  logic [1:0] m_of = 2'b00, m_neg = 2'b00, m_zero = 2'b00;
  bit         m_full = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] enc(input bit v);
    return v ? 2'b10 : 2'b01;
  endfunction

  function automatic bit pair_ok(input logic [1:0] p);
    return (p == 2'b01) || (p == 2'b10);
  endfunction

  function automatic int val(input logic [7:0] x);
    int v = 0;
    for (int i = 0; i < 4; i++) if (x[2*i +: 2] == 2'b10) v += (1 << i);
    return v;
  endfunction

  function automatic logic [7:0] rand_dr();
    logic [7:0] x;
    for (int i = 0; i < 4; i++) x[2*i +: 2] = enc(bit'($urandom_range(0, 1)));
    return x;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v, input int tag);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s tag=%0d actual=%b required=%b", nm, tag, act, exp_v);
    end
  endtask

  // Drive one cycle of inputs and push the register content expected after the next edge.
  task automatic step(input logic r, input logic [7:0] ta, input logic [7:0] tbv,
                      input logic [1:0] top, input logic tack, input int tag);
    bit   complete;
    bit   is_null;
    int   sa, sb, res;
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; a = ta; b = tbv; opr = top; ack_in = tack;
    complete = pair_ok(top);
    for (int i = 0; i < 4; i++)
      complete = complete && pair_ok(ta[2*i +: 2]) && pair_ok(tbv[2*i +: 2]);
    is_null = (ta == 8'h00) && (tbv == 8'h00) && (top == 2'b00);
    if (r) begin
      m_full = 0; m_soma = 8'h00; m_of = 2'b00; m_neg = 2'b00; m_zero = 2'b00;
    end else if (!m_full && tack && complete) begin
      sa = val(ta); if (sa > 7) sa -= 16;
      sb = val(tbv); if (sb > 7) sb -= 16;
      res = (top == 2'b10) ? sa - sb : sa + sb;
      m_of   = enc(res > 7 || res < -8);
      m_neg  = enc((res & 15) >= 8);
      m_zero = enc((res & 15) == 0);
      for (int i = 0; i < 4; i++) m_soma[2*i +: 2] = enc(((res >> i) & 1) == 1);
      m_full = 1;
    end else if (m_full && !tack && is_null) begin
      m_full = 0; m_soma = 8'h00; m_of = 2'b00; m_neg = 2'b00; m_zero = 2'b00;
    end
    e.soma = m_soma; e.of = m_of; e.neg = m_neg; e.zero = m_zero;
    e.ack = !m_full; e.due = cyc + 1; e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Monitor: compares the DUT against the scoreboard entry due this cycle, plus invariants.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
      mon_e = sb_q.pop_front();
      tests++; fails++;
      $display("FAIL stale_entry tag=%0d actual=cycle %0d required=cycle %0d", mon_e.tag, cyc, mon_e.due);
    end
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      mon_e = sb_q.pop_front();
      chk("soma", soma, mon_e.soma, mon_e.tag);
      chk("of", {6'b0, of}, {6'b0, mon_e.of}, mon_e.tag);
      chk("neg", {6'b0, neg}, {6'b0, mon_e.neg}, mon_e.tag);
      chk("zero", {6'b0, zero}, {6'b0, mon_e.zero}, mon_e.tag);
      chk("ack_out", {7'b0, ack_out}, {7'b0, mon_e.ack}, mon_e.tag);
      check_on = 1;
    end
    if (check_on) begin
      mon_w = {soma, of, neg, zero};
      mon_bad = 0;
      for (int i = 0; i < 7; i++) if (mon_w[2*i +: 2] == 2'b11) mon_bad = 1;
      chk("no_illegal_pair", {7'b0, mon_bad}, 8'h00, cyc);
      chk("ack_vs_null", {7'b0, ack_out}, {7'b0, (mon_w == 14'h0)}, cyc);
    end
  end

  logic [7:0] ra, rb;
  logic [1:0] ro;
  logic       rack;
  int         kind, p;

  initial begin
    // Reset, then the directed wavefronts.
    step(1, 8'h00, 8'h00, 2'b00, 0, 1);
    step(0, 8'b01011010, 8'b10101010, 2'b01, 1, 2);    // ADD 3 + 15
    step(0, 8'h00, 8'h00, 2'b00, 0, 3);                // NULL return
    step(0, 8'b01101010, 8'b10101010, 2'b10, 1, 4);    // SUB 7 - (-1), overflow
    step(0, 8'h00, 8'h00, 2'b00, 0, 5);
    step(0, 8'b01010101, 8'b01010101, 2'b01, 0, 6);    // DATA without request: hold NULL
    step(0, 8'b01010101, 8'b01010101, 2'b01, 1, 7);    // zero result
    step(0, 8'b01010100, 8'b01010101, 2'b01, 0, 8);    // partial NULL: hold DATA
    step(0, 8'h00, 8'h00, 2'b00, 0, 9);
    step(0, 8'b01011010, 8'b10101010, 2'b01, 1, 10);   // reset while holding DATA
    step(1, 8'b01011010, 8'b10101010, 2'b01, 1, 11);
    step(0, 8'h00, 8'h00, 2'b00, 0, 12);

    // Stress: alternating DATA/NULL wavefronts, ack_out must toggle each cycle.
    for (int n = 0; n < 100; n++) begin
      step(0, 8'b01011010, 8'b10101010, 2'b01, 1, 100 + 2*n);
      step(0, 8'h00, 8'h00, 2'b00, 0, 101 + 2*n);
    end

    // Randomized wavefronts, including partial, illegal and unrequested ones.
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 5);
      ra = rand_dr(); rb = rand_dr(); ro = enc(bit'($urandom_range(0, 1)));
      p = $urandom_range(0, 3);
      case (kind)
        2: begin ra = 8'h00; rb = 8'h00; ro = 2'b00; end
        3: ra[2*p +: 2] = 2'b00;
        4: rb[2*p +: 2] = 2'b11;
        5: begin ra = 8'h00; ro = 2'b00; rb = 8'h00; rb[2*p +: 2] = 2'b01; end
        default: ;
      endcase
      if (m_full) rack = ($urandom_range(0, 3) == 0);
      else        rack = ($urandom_range(0, 3) != 0);
      step((n == 200) ? 1'b1 : 1'b0, ra, rb, ro, rack, 1000 + n);
    end

    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain actual=%0d entries required=0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
